// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch/decode boundary.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0 -- shown to decode whenever the buffer is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer_predecode.sv
// Early classification of an instruction word so decode gets the
// control-flow and illegal-encoding hints without re-examining the opcode.
module predecode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic        ctrl_flow,
    output logic        illegal
);

    // Jumps and branches redirect fetch; anything not ending in 2'b11 is a
    // compressed or invalid encoding, which this core does not support.
    always_comb begin
        ctrl_flow = (instr[6:0] == OPC_JAL)  ||
                    (instr[6:0] == OPC_JALR) ||
                    (instr[6:0] == OPC_BRANCH);
        illegal   = (instr[1:0] != 2'b11);
    end

endmodule

// File: rtl/if_id_buffer.sv
// Small circular queue between fetch and decode. Fetch is throttled through
// pc_en_o, decode drains the head under valid/ready, and a redirect flush
// throws away every queued wrong-path entry.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pcF_i,
    input  logic [31:0]     instrF_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] pcD_o,
    output logic [31:0]     instrD_o,
    output logic            ctrl_flowD_o,
    output logic            illegalD_o,
    output logic [31:0]     stall_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if_id_entry_t entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   stall_cnt;

    logic         push;
    logic         pop;
    if_id_entry_t head;

    // Enable is deliberately blind to id_ready_i so there is no
    // combinational path from decode back into fetch; a flush always lets
    // fetch load the redirect target.
    always_comb begin
        pc_en_o    = (count < FULL_COUNT) || flush_i;
        id_valid_o = (count != '0);
        push       = pc_en_o && !flush_i;
        pop        = id_valid_o && id_ready_i && !flush_i;
    end

    // Present the oldest entry, or a harmless NOP at PC 0 when empty.
    always_comb begin
        head.pc    = '0;
        head.instr = NOP_INSTR;
        if (id_valid_o) begin
            head = entries[rd_ptr];
        end
    end

    predecode u_predecode (
        .instr     (head.instr),
        .ctrl_flow (ctrl_flowD_o),
        .illegal   (illegalD_o)
    );

    assign pcD_o       = head.pc;
    assign instrD_o    = head.instr;
    assign stall_cnt_o = stall_cnt;

    // Queue pointers, occupancy and storage; flush empties the queue but
    // leaves stale data in place since count alone decides validity.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr].pc    <= pcF_i;
                entries[wr_ptr].instr <= instrF_i;
                wr_ptr                <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Free-running count of cycles in which fetch was held; survives flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!pc_en_o) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised and directed bench for if_id_buffer with a queue-based
// reference model and a decoupled monitor that checks the decode side.
module tb_if_id_buffer;
    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pcF_i = '0;
    logic [31:0] instrF_i = '0;
    logic        flush_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic        pc_en_o;
    logic        id_valid_o;
    logic [31:0] pcD_o;
    logic [31:0] instrD_o;
    logic        ctrl_flowD_o;
    logic        illegalD_o;
    logic [31:0] stall_cnt_o;

    if_id_entry_t exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] stall_model = '0;
    logic [31:0] pc_f = 32'h8000_0000;
    logic        done = 1'b0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pcF_i        (pcF_i),
        .instrF_i     (instrF_i),
        .pc_en_o      (pc_en_o),
        .flush_i      (flush_i),
        .id_ready_i   (id_ready_i),
        .id_valid_o   (id_valid_o),
        .pcD_o        (pcD_o),
        .instrD_o     (instrD_o),
        .ctrl_flowD_o (ctrl_flowD_o),
        .illegalD_o   (illegalD_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    function automatic logic is_ctrl(input logic [31:0] instr);
        return instr[6:0] inside {7'h6F, 7'h67, 7'h63};
    endfunction

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_006F;
            1:       return 32'h0000_8067;
            2:       return 32'h0000_0063;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0013;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // One fetch cycle: drive at negedge, then update the model after the edge.
    task automatic applyStimulus(input logic rst, input logic flush, input logic ready,
                                 input logic [31:0] instr, input logic [31:0] target);
        logic will_push;
        @(negedge clk);
        rst_i      = rst;
        flush_i    = flush;
        id_ready_i = ready;
        pcF_i      = pc_f;
        instrF_i   = instr;
        will_push  = !rst && !flush && (exp_q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            pc_f = 32'h8000_0000;
        end else if (flush) begin
            exp_q.delete();
            pc_f = target;
        end else if (will_push) begin
            if_id_entry_t e;
            e.pc    = pc_f;
            e.instr = instr;
            exp_q.push_back(e);
            pc_f = pc_f + 32'd4;
        end
    endtask

    // Monitor: checks the decode side mid-cycle and retires the head on a handshake.
    initial begin
        forever begin
            logic         exp_pc_en;
            if_id_entry_t head;
            @(negedge clk);
            #3;
            if (done) break;
            if (rst_i) begin
                stall_model = '0;
                continue;
            end
            exp_pc_en = (exp_q.size() < DEPTH) || flush_i;
            checkOutput("pc_en", 64'(pc_en_o), 64'(exp_pc_en));
            checkOutput("id_valid", 64'(id_valid_o), 64'(exp_q.size() != 0));
            checkOutput("stall_cnt", 64'(stall_cnt_o), 64'(stall_model));
            if (exp_q.size() == 0) begin
                checkOutput("empty_pc", 64'(pcD_o), 64'd0);
                checkOutput("empty_instr", 64'(instrD_o), 64'h13);
                checkOutput("empty_ctrl", 64'(ctrl_flowD_o), 64'd0);
                checkOutput("empty_illegal", 64'(illegalD_o), 64'd0);
            end else begin
                head = exp_q[0];
                checkOutput("head_pc", 64'(pcD_o), 64'(head.pc));
                checkOutput("head_instr", 64'(instrD_o), 64'(head.instr));
                checkOutput("head_ctrl", 64'(ctrl_flowD_o), 64'(is_ctrl(head.instr)));
                checkOutput("head_illegal", 64'(illegalD_o), 64'(head.instr[1:0] != 2'b11));
                if (id_ready_i && !flush_i) void'(exp_q.pop_front());
            end
            if (!exp_pc_en) stall_model = stall_model + 32'd1;
        end
    end

    // Directed scenarios followed by a random soak.
    initial begin
        applyStimulus(1, 0, 0, NOP_INSTR, '0);
        applyStimulus(1, 0, 0, NOP_INSTR, '0);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, pick_instr(), '0);

        applyStimulus(1, 0, 0, NOP_INSTR, '0);
        applyStimulus(0, 0, 0, 32'h0000_006F, '0);
        applyStimulus(0, 0, 0, 32'h0000_8067, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, pick_instr(), '0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, pick_instr(), '0);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, pick_instr(), '0);
        applyStimulus(0, 1, 0, pick_instr(), 32'h8000_0100);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, pick_instr(), '0);

        applyStimulus(0, 0, 1, pick_instr(), '0);
        applyStimulus(0, 1, 1, pick_instr(), 32'h8000_0200);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, pick_instr(), '0);

        applyStimulus(0, 0, 1, 32'h0000_006F, '0);
        applyStimulus(0, 0, 1, 32'h0000_8067, '0);
        applyStimulus(0, 0, 1, 32'h0000_0063, '0);
        applyStimulus(0, 0, 1, 32'h0000_0000, '0);
        applyStimulus(0, 0, 1, 32'h0000_0013, '0);

        applyStimulus(0, 0, 0, pick_instr(), '0);
        applyStimulus(0, 0, 0, pick_instr(), '0);
        applyStimulus(0, 0, 0, pick_instr(), '0);
        applyStimulus(1, 0, 0, pick_instr(), '0);
        applyStimulus(0, 0, 0, pick_instr(), '0);

        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1,
                          pick_instr(),
                          32'h8000_0000 + ($urandom_range(0, 255) << 2));
        end

        applyStimulus(0, 0, 1, pick_instr(), '0);
        done = 1'b1;
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction buffer between the fetch stage and decode: captures each (PC, instruction) pair presented by fetch into a small circular queue, throttles fetch through its PC enable, and presents the oldest entry to decode under a valid/ready handshake. It also predecodes control-flow and illegal-encoding flags, discards wrong-path entries on a redirect flush, and counts fetch-stall cycles for performance analysis.

## Interface
Parameters:
- DEPTH, 2, number of queue entries; power of two, at least 2.

Ports (`XLEN` from `riscv_pkg`):
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pcF_i  input  XLEN  PC currently presented by fetch.
- instrF_i  input  32  instruction at pcF_i, combinational from fetch.
- pc_en_o  output  1  to fetch: advance the PC this cycle; when 1 and no flush, the pcF_i/instrF_i pair is captured.
- flush_i  input  1  redirect from execute, asserted together with fetch's next-PC enable; discard all entries.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- id_valid_o  output  1  head entry valid.
- pcD_o  output  XLEN  head entry PC.
- instrD_o  output  32  head entry instruction.
- ctrl_flowD_o  output  1  head opcode[6:0] is JAL (1101111), JALR (1100111) or BRANCH (1100011).
- illegalD_o  output  1  head instr[1:0] != 2'b11.
- stall_cnt_o  output  32  count of cycles with pc_en_o == 0.

## Operation
- Storage: DEPTH entries of {pc, instr}; rd_ptr and wr_ptr of width $clog2(DEPTH); count of width $clog2(DEPTH)+1.
- pc_en_o = (count < DEPTH) || flush_i. This is combinational from registered state and flush_i only; it has no path from id_ready_i.
- push = pc_en_o && !flush_i: write {pcF_i, instrF_i} at wr_ptr, then increment wr_ptr modulo DEPTH.
- pop = id_valid_o && id_ready_i && !flush_i: increment rd_ptr modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- flush_i:
  - Sets count, rd_ptr and wr_ptr to 0.
  - No push and no pop that cycle; flush wins over any simultaneous handshake.
  - pc_en_o = 1 so fetch loads the redirect target.
- id_valid_o = (count != 0).
- When empty: pcD_o = 0, instrD_o = 32'h0000_0013 (NOP), ctrl_flowD_o = 0, illegalD_o = 0.
- When not empty: outputs are the entry at rd_ptr; flags are decoded from that entry.
- stall_cnt_o increments by 1 every cycle pc_en_o == 0 and wraps at 2^32. Flush does not clear it.
- Reset clears count, both pointers, every entry and stall_cnt_o. Reset mid-operation drops all entries with no pop reported.

## Timing
- Latency:
  - An instruction pushed at edge N is visible on the decode outputs after edge N, if the queue was empty.
  - Otherwise it becomes visible after all older entries have been popped.
- Throughput:
  - With DEPTH ≥ 2 and id_ready_i held at 1, one instruction per cycle; count settles at 1.
  - When count == DEPTH, fetch stalls for one cycle even if id_ready_i = 1 that cycle, since pc_en_o does not look at id_ready_i. The queue then drains to DEPTH-1 and the next cycle pushes.
- Output values in the cycle after reset:
  - id_valid_o = 0, pc_en_o = 1, stall_cnt_o = 0.
  - pcD_o = 0, instrD_o = NOP.
- Decode must hold id_ready_i meaningful only while id_valid_o = 1. id_ready_i is ignored when the queue is empty.
- Full + flush_i: pc_en_o = 1 and the queue is emptied; the cycle is not counted as a stall.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

## Structure
- `riscv_pkg` gains:
  - opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH.
  - `localparam NOP_INSTR = 32'h0000_0013`.
  - packed struct `if_id_entry_t` {pc[XLEN-1:0], instr[31:0]}.
- One sub-module is natural: `predecode`, combinational, taking a 32-bit instruction and producing ctrl_flow and illegal.
- Queue control, storage and the stall counter stay in `if_id_buffer`.

## Test plan
- Reset, then id_ready_i = 1 and sequential fetch from 0x8000_0000 → id_valid_o rises one cycle after reset release. Decode outputs follow 0x8000_0000, 0x8000_0004, … one per cycle, with pc_en_o constantly 1 and stall_cnt_o = 0.
- id_ready_i = 0 from reset → two pushes (0x8000_0000, 0x8000_0004), then pc_en_o = 0. stall_cnt_o increments each further cycle. Raising id_ready_i pops 0x8000_0000 first, and pc_en_o returns to 1 the cycle after.
- Full queue, then flush_i for one cycle → pc_en_o = 1 that cycle; id_valid_o = 0 the next cycle; the redirect PC (e.g. 0x8000_0100) is the next entry shown.
- Flush coinciding with a valid handshake → no pop is counted; queue empty; no instruction from before the flush ever reaches decode.
- Head instructions 0x0000_006F (JAL), 0x0000_8067 (JALR), 0x0000_0063 (BRANCH), 0x0000_0000 → ctrl_flowD_o = 1, 1, 1, 0; illegalD_o = 1 only for 0x0000_0000.
- rst_i asserted with two entries queued → next cycle id_valid_o = 0, instrD_o = 0x0000_0013, stall_cnt_o = 0, pc_en_o = 1.
